// File: rtl/tone_mixer_pwm.sv
// Multi-voice square-wave tone generator with a frame-latched PWM DAC.
// Voice amplitudes are summed and applied as duty only on frame boundaries.
module tone_mixer_pwm #(
  parameter int N      = 8,
  parameter int VOICES = 4,
  parameter int DIV_W  = 12,
  parameter int PRESC  = 4,
  parameter int VOL_W  = N - $clog2(VOICES),
  localparam int SEL_W = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [DIV_W-1:0] cfg_period,
  input  logic [VOL_W-1:0] cfg_vol,
  input  logic             cfg_on,
  output logic             pwm_out,
  output logic [N-1:0]     mix_o,
  output logic [N-1:0]     duty_o,
  output logic             frame_start
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0]    presc;
  logic             tick;
  logic [DIV_W-1:0] period [VOICES];
  logic [DIV_W-1:0] cnt    [VOICES];
  logic [VOL_W-1:0] vol    [VOICES];
  logic             on     [VOICES];
  logic             phase  [VOICES];
  logic [N-1:0]     sum;
  logic [N-1:0]     pwm_cnt;
  logic [N-1:0]     cnt_next;
  logic [N-1:0]     duty_next;

  assign tick = (presc == PW'(PRESC - 1));

  // A write on a tick edge restarts the voice; the tick is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
        vol[i]    <= '0;
        on[i]     <= 1'b0;
        phase[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (cfg_we && (int'(cfg_sel) == i)) begin
          period[i] <= cfg_period;
          vol[i]    <= cfg_vol;
          on[i]     <= cfg_on;
          cnt[i]    <= '0;
          phase[i]  <= 1'b0;
        end else if (!on[i] || (period[i] == '0)) begin
          cnt[i]   <= '0;
          phase[i] <= 1'b0;
        end else if (tick) begin
          if (cnt[i] == '0) begin
            cnt[i]   <= period[i] - DIV_W'(1);
            phase[i] <= ~phase[i];
          end else begin
            cnt[i] <= cnt[i] - DIV_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (phase[i]) sum = sum + N'(vol[i]);
    end
  end

  assign cnt_next  = pwm_cnt + N'(1);
  assign duty_next = (pwm_cnt == '1) ? mix_o : duty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
      mix_o   <= '0;
      duty_o  <= '0;
      pwm_out <= 1'b0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      pwm_cnt <= cnt_next;
      mix_o   <= sum;
      duty_o  <= duty_next;
      pwm_out <= (cnt_next < duty_next);
    end
  end

  assign frame_start = !reset && (pwm_cnt == '0);

endmodule

// File: tb/tb_tone_mixer_pwm.sv
// Bench for tone_mixer_pwm: directed scenarios plus random writes,
// checked every cycle against a closed-form timing model.
module tb_tone_mixer_pwm;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [11:0] cfg_period;
  logic [5:0] cfg_vol;
  logic       cfg_on;
  logic       pwm_out;
  logic [7:0] mix_o;
  logic [7:0] duty_o;
  logic       frame_start;

  tone_mixer_pwm dut (
    .clk(clk),
    .reset(reset),
    .cfg_we(cfg_we),
    .cfg_sel(cfg_sel),
    .cfg_period(cfg_period),
    .cfg_vol(cfg_vol),
    .cfg_on(cfg_on),
    .pwm_out(pwm_out),
    .mix_o(mix_o),
    .duty_o(duty_o),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: per voice, edge of last write and its settings
  int w_e [4];
  int per [4];
  int vl  [4];
  bit on_m [4];
  int ecount = 0;
  int exp_mix = 0;
  int exp_duty = 0;
  int exp_pwm = 0;
  int amp_sum = 0;
  int hi_cnt = 0;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d at edge %0d", tag, got, want, ecount);
    end
  endtask

  // phase after edge e: ticks fall on edges with e%4==0, the first
  // tick after a write toggles, then every per-th tick toggles again
  function automatic int phase_of(input int v, input int e);
    int k;
    if (!on_m[v] || per[v] == 0) return 0;
    k = e / 4 - w_e[v] / 4;
    if (k <= 0) return 0;
    return (((k - 1) / per[v]) + 1) % 2;
  endfunction

  task automatic step(input bit rst, input bit we, input int sel,
                      input int p, input int v, input bit o);
    reset      = rst;
    cfg_we     = we;
    cfg_sel    = 2'(sel);
    cfg_period = 12'(p);
    cfg_vol    = 6'(v);
    cfg_on     = o;
    #1;
    chk("frame_start", int'(frame_start),
        (!rst && (ecount % 256 == 0)) ? 1 : 0);
    @(posedge clk);
    if (rst) begin
      ecount = 0;
      for (int i = 0; i < 4; i++) begin
        w_e[i] = 0; per[i] = 0; vl[i] = 0; on_m[i] = 0;
      end
      exp_mix = 0; exp_duty = 0; exp_pwm = 0;
      amp_sum = 0; hi_cnt = 0;
    end else begin
      ecount++;
      if (we) begin
        w_e[sel] = ecount; per[sel] = p; vl[sel] = v; on_m[sel] = o;
      end
      if (ecount % 256 == 0) exp_duty = exp_mix;
      exp_mix = amp_sum;
      exp_pwm = ((ecount % 256) < exp_duty) ? 1 : 0;
      amp_sum = 0;
      for (int i = 0; i < 4; i++) amp_sum += vl[i] * phase_of(i, ecount);
    end
    @(negedge clk);
    chk("mix", int'(mix_o), exp_mix);
    chk("duty", int'(duty_o), exp_duty);
    chk("pwm", int'(pwm_out), exp_pwm);
    if (!rst) begin
      if (ecount % 256 == 0) hi_cnt = 0;
      hi_cnt += int'(pwm_out);
      if (ecount % 256 == 255) chk("frame_high", hi_cnt, exp_duty);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int sel, input int p, input int v, input bit o);
    step(0, 1, sel, p, v, o);
  endtask

  initial begin
    // reset and idle frames
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    chk("rst_pwm", int'(pwm_out), 0);
    idle(600);

    // single tone
    step(1, 0, 0, 0, 0, 0);
    wr(0, 3, 63, 1);
    idle(100);

    // full mix to 252
    for (int i = 0; i < 4; i++) wr(i, 100, 63, 1);
    idle(8);
    chk("mix_full", int'(mix_o), 252);
    while (ecount % 256 != 0) idle(1);
    chk("duty_full", int'(duty_o), 252);
    idle(300);

    // mid-frame mix change latched only at the boundary
    step(1, 0, 0, 0, 0, 0);
    while (ecount < 96) idle(1);
    wr(0, 1000, 40, 1);
    while (ecount < 255) idle(1);
    chk("duty_cur", int'(duty_o), 0);
    idle(1);
    chk("duty_next", int'(duty_o), 40);
    idle(256);

    // silence cases
    step(1, 0, 0, 0, 0, 0);
    wr(1, 0, 63, 1);
    wr(2, 5, 63, 0);
    idle(40);
    chk("silent_mix", int'(mix_o), 0);
    wr(3, 200, 50, 1);
    idle(6);
    chk("voice3_on", int'(mix_o), 50);
    wr(3, 200, 50, 0);
    idle(1);
    chk("voice3_off", int'(mix_o), 0);

    // reset in the middle of a frame
    step(1, 0, 0, 0, 0, 0);
    wr(0, 500, 63, 1);
    wr(1, 500, 63, 1);
    while (!(ecount > 10 && ecount % 256 == 0)) idle(1);
    chk("duty_126", int'(duty_o), 126);
    while (ecount % 256 != 50) idle(1);
    step(1, 0, 0, 0, 0, 0);
    chk("mid_rst_pwm", int'(pwm_out), 0);
    chk("mid_rst_duty", int'(duty_o), 0);
    idle(300);

    // random writes
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 8 == 0)
        wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
           int'($urandom_range(0, 63)), ($urandom % 4) != 0);
      else
        idle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
